// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment table, digit
// enable positions and the glitch-filter state type.
package seg7_pkg;

  // Digit enable bits forced high (off) before the segment table lookup
  localparam logic [11:0] DIGIT_MASK = 12'h9A0;

  // Normalised bus codes for numerals 0..9 (digit bits already forced off)
  localparam logic [11:0] SEG7_CODE [0:9] = '{
    12'hFEB, 12'h9E8, 12'hDF3, 12'hDFA, 12'hBF8,
    12'hFBA, 12'hFBB, 12'hDE8, 12'hFFB, 12'hFFA
  };

  // Active-low digit enable positions on the bus
  localparam int EN_D1_BIT = 11;
  localparam int EN_D2_BIT = 8;
  localparam int EN_D3_BIT = 7;
  localparam int EN_D4_BIT = 5;

  // Glitch filter: TRACK counts stable samples, HELD waits for the next change
  typedef enum logic {
    TRACK = 1'b0,
    HELD  = 1'b1
  } filt_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one display bus sample: numeral lookup on the
// normalised segment code and classification of the digit enables.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [11:0] bus_i,
  output logic        pat_valid_o,
  output logic [3:0]  value_o,
  output logic        blank_o,
  output logic        multi_o,
  output logic [1:0]  idx_o
);

  logic [11:0] code;
  logic [3:0]  lit;     // [3]=D1 .. [0]=D4, 1 = digit enabled
  logic        single;

  assign code = bus_i | DIGIT_MASK;
  assign lit  = ~{bus_i[EN_D1_BIT], bus_i[EN_D2_BIT], bus_i[EN_D3_BIT], bus_i[EN_D4_BIT]};

  // Segment table lookup; unmatched codes are reported as invalid
  always_comb begin
    pat_valid_o = 1'b0;
    value_o     = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (code == SEG7_CODE[i]) begin
        pat_valid_o = 1'b1;
        value_o     = 4'(i);
      end
    end
  end

  // Enable classification: exactly one digit lit gives its index
  always_comb begin
    single = 1'b1;
    idx_o  = 2'd0;
    case (lit)
      4'b1000: idx_o = 2'd3;
      4'b0100: idx_o = 2'd2;
      4'b0010: idx_o = 2'd1;
      4'b0001: idx_o = 2'd0;
      default: single = 1'b0;
    endcase
  end

  assign blank_o = (lit == 4'b0000);
  assign multi_o = !blank_o && !single;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed 4-digit display: synchronises the bus,
// filters glitches, recovers per-digit BCD readback with staleness timeout
// and reports malformed patterns.
//
// No handshake: update_pulse, pattern_err and enable_err are single-cycle
// strobes with no back-pressure; bcd_out/digit_valid/update_digit are
// registered levels that are valid every cycle.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] hex_in,
  input  logic        err_clr,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_valid,
  output logic        update_pulse,
  output logic [1:0]  update_digit,
  output logic        pattern_err,
  output logic        enable_err,
  output logic [7:0]  err_count
);

  localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

  logic [11:0]     sync1_q, sync2_q, prev_q;
  filt_state_e     state_q;
  logic [SCW-1:0]  stab_cnt_q;
  logic [3:0]      digit_q [4];
  logic [TCW-1:0]  to_cnt_q [4];
  logic [3:0]      valid_q;
  logic            pulse_q, perr_q, eerr_q;
  logic [1:0]      upd_digit_q;
  logic [7:0]      err_cnt_q;

  logic            same_d, accept_d, err_event_d;
  logic            pat_valid, blank, multi, single;
  logic [3:0]      value;
  logic [1:0]      idx;

  seg7_pattern_decode u_decode (
    .bus_i       (sync2_q),
    .pat_valid_o (pat_valid),
    .value_o     (value),
    .blank_o     (blank),
    .multi_o     (multi),
    .idx_o       (idx)
  );

  assign single      = !blank && !multi;
  assign same_d      = (sync2_q == prev_q);
  assign accept_d    = (state_q == TRACK) && same_d && (stab_cnt_q == STAB_LAST);
  assign err_event_d = accept_d && (multi || (single && !pat_valid));

  // Two-flop synchroniser plus the previous synced sample for change detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= DIGIT_MASK;
      sync2_q <= DIGIT_MASK;
      prev_q  <= DIGIT_MASK;
    end else begin
      sync1_q <= hex_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Glitch filter: accept once per stable run, re-arm on any change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TRACK;
      stab_cnt_q <= '0;
    end else begin
      case (state_q)
        TRACK: begin
          if (!same_d)                     stab_cnt_q <= '0;
          else if (stab_cnt_q == STAB_LAST) state_q    <= HELD;
          else                             stab_cnt_q <= stab_cnt_q + 1'b1;
        end
        HELD: begin
          if (!same_d) begin
            state_q    <= TRACK;
            stab_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= TRACK;
          stab_cnt_q <= '0;
        end
      endcase
    end
  end

  // Digit registers, staleness timeout and strobes; an accept overrides a timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        digit_q[i]  <= '0;
        to_cnt_q[i] <= '0;
      end
      valid_q     <= '0;
      pulse_q     <= 1'b0;
      perr_q      <= 1'b0;
      eerr_q      <= 1'b0;
      upd_digit_q <= 2'd0;
    end else begin
      pulse_q <= 1'b0;
      perr_q  <= 1'b0;
      eerr_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (valid_q[i]) begin
          if (to_cnt_q[i] == TO_LAST) valid_q[i]  <= 1'b0;
          else                        to_cnt_q[i] <= to_cnt_q[i] + 1'b1;
        end
      end
      if (accept_d) begin
        if (single) begin
          if (pat_valid) begin
            digit_q[idx]  <= value;
            valid_q[idx]  <= 1'b1;
            to_cnt_q[idx] <= '0;
            pulse_q       <= 1'b1;
            upd_digit_q   <= idx;
          end else begin
            perr_q       <= 1'b1;
            valid_q[idx] <= 1'b0;
          end
        end else if (multi) begin
          eerr_q <= 1'b1;
        end
      end
    end
  end

  // Saturating error counter; a clear wins over a same-cycle error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 8'd0;
    end else if (err_clr) begin
      err_cnt_q <= 8'd0;
    end else if (err_event_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bcd_out      = {digit_q[3], digit_q[2], digit_q[1], digit_q[0]};
  assign digit_valid  = valid_q;
  assign update_pulse = pulse_q;
  assign update_digit = upd_digit_q;
  assign pattern_err  = perr_q;
  assign enable_err   = eerr_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: behavioural model of the display readback,
// per-cycle comparison against it, and directed scenarios with literal checks.
module tb_seg7_scan_decoder;

  localparam int S = 4;
  localparam int T = 64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] hex_in = 12'h9A0;
  logic        err_clr = 1'b0;

  logic [15:0] bcd_out;
  logic [3:0]  digit_valid;
  logic        update_pulse;
  logic [1:0]  update_digit;
  logic        pattern_err;
  logic        enable_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hex_in       (hex_in),
    .err_clr      (err_clr),
    .bcd_out      (bcd_out),
    .digit_valid  (digit_valid),
    .update_pulse (update_pulse),
    .update_digit (update_digit),
    .pattern_err  (pattern_err),
    .enable_err   (enable_err),
    .err_count    (err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pattern present on the bus from edge k is accepted at edge k+2+S:
  // two sync stages, then S+1 identical synced samples. The model tracks
  // the run length of the bus value as seen two edges late.
  logic [11:0] m_tab [10] = '{12'hFEB, 12'h9E8, 12'hDF3, 12'hDFA, 12'hBF8,
                              12'hFBA, 12'hFBB, 12'hDE8, 12'hFFB, 12'hFFA};
  int          en_pos [4] = '{5, 7, 8, 11};  // index 0=D4 .. 3=D1
  logic [11:0] m_h1, m_h2, m_run_val;
  int          m_run_len;
  logic [3:0]  m_dig [4];
  int          m_age [4];
  logic [3:0]  m_valid;
  logic        m_pulse, m_perr, m_eerr;
  logic [1:0]  m_upd;
  int          m_errs;
  logic [1:0]  exp_q [$];

  always @(posedge clk or negedge reset_n) begin : model
    logic [11:0] d;
    int nlit, li, val;
    if (!reset_n) begin
      m_h1 = 12'h9A0; m_h2 = 12'h9A0; m_run_val = 12'h9A0; m_run_len = 1000;
      for (int i = 0; i < 4; i++) begin m_dig[i] = 4'd0; m_age[i] = 0; end
      m_valid = 4'd0; m_pulse = 1'b0; m_perr = 1'b0; m_eerr = 1'b0;
      m_upd = 2'd0; m_errs = 0;
      exp_q.delete();
    end else begin
      d = m_h2; m_h2 = m_h1; m_h1 = hex_in;
      if (d == m_run_val) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_val = d; m_run_len = 1;
      end
      m_pulse = 1'b0; m_perr = 1'b0; m_eerr = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i]) begin
          m_age[i]++;
          if (m_age[i] >= T) m_valid[i] = 1'b0;
        end
      end
      if (m_run_len == S + 1) begin
        nlit = 0; li = 0; val = -1;
        for (int i = 0; i < 4; i++) if (!d[en_pos[i]]) begin nlit++; li = i; end
        for (int v = 0; v < 10; v++) if ((d | 12'h9A0) == m_tab[v]) val = v;
        if (nlit > 1) m_eerr = 1'b1;
        else if (nlit == 1) begin
          if (val >= 0) begin
            m_dig[li] = val[3:0]; m_valid[li] = 1'b1; m_age[li] = 0;
            m_pulse = 1'b1; m_upd = li[1:0]; exp_q.push_back(li[1:0]);
          end else begin
            m_perr = 1'b1; m_valid[li] = 1'b0;
          end
        end
      end
      if (err_clr) m_errs = 0;
      else if ((m_perr || m_eerr) && m_errs < 255) m_errs++;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int         pulse_cnt = 0;
  int         last_pulse_edge = 0;
  int         perr_cnt = 0;
  int         eerr_cnt = 0;
  logic [1:0] dlog [$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("bcd_out", 32'(bcd_out), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
      check("digit_valid", 32'(digit_valid), 32'(m_valid));
      check("update_pulse", 32'(update_pulse), 32'(m_pulse));
      check("update_digit", 32'(update_digit), 32'(m_upd));
      check("pattern_err", 32'(pattern_err), 32'(m_perr));
      check("enable_err", 32'(enable_err), 32'(m_eerr));
      check("err_count", 32'(err_count), 32'(m_errs));
      if (pattern_err) perr_cnt++;
      if (enable_err) eerr_cnt++;
      if (update_pulse) begin
        pulse_cnt++;
        last_pulse_edge = ecount;
        dlog.push_back(update_digit);
        check("pulse_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("pulse_digit", 32'(update_digit), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic show(input logic [11:0] v, input int cycles);
    @(negedge clk);
    hex_in = v;
    repeat (cycles - 1) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  logic [11:0] scan_v [4] = '{12'h7FA, 12'hCFA, 12'hF3A, 12'hDC8};
  int          exp_order [4] = '{3, 2, 1, 0};
  int k, p0, e0, a, r1;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_bcd", 32'(bcd_out), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_errs", 32'(err_count), 32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: D4 '0' held
    @(negedge clk);
    hex_in = 12'hFCB; k = ecount + 1; p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    check("t1_pulse_count", 32'(pulse_cnt - p0), 32'd1);
    check("t1_pulse_edge", 32'(last_pulse_edge), 32'(k + 6));
    check("t1_update_digit", 32'(update_digit), 32'd0);
    check("t1_bcd_d4", 32'(bcd_out[3:0]), 32'd0);
    check("t1_valid", 32'(digit_valid), 32'b0001);

    // 2: round-robin scan 9,3,5,7
    p0 = pulse_cnt; dlog.delete();
    for (int i = 0; i < 4; i++) show(scan_v[i], 8);
    repeat (2) @(negedge clk);
    check("t2_pulse_count", 32'(pulse_cnt - p0), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < dlog.size()) check("t2_pulse_order", 32'(dlog[i]), 32'(exp_order[i]));
    check("t2_bcd", 32'(bcd_out), 32'h9357);
    check("t2_valid", 32'(digit_valid), 32'hF);

    // 3: glitches to D4 '4' between stable D4 '0'; only the '0' is re-accepted
    show(12'hFCB, 10);
    p0 = pulse_cnt;
    show(12'hBD8, 1);
    show(12'hFCB, 10);
    show(12'hBD8, 3);
    show(12'hFCB, 10);
    check("t3_pulses", 32'(pulse_cnt - p0), 32'd2);
    check("t3_bcd_d4", 32'(bcd_out[3:0]), 32'd0);
    check("t3_valid_d4", 32'(digit_valid[0]), 32'd1);

    // 4: enable and pattern errors, saturation, clear
    e0 = eerr_cnt;
    show(12'h000, 10);
    check("t4_enable_err_once", 32'(eerr_cnt - e0), 32'd1);
    check("t4_err_count_1", 32'(err_count), 32'd1);
    e0 = perr_cnt;
    show(12'hFC3, 10);
    check("t4_pattern_err_once", 32'(perr_cnt - e0), 32'd1);
    check("t4_valid_d4_cleared", 32'(digit_valid[0]), 32'd0);
    check("t4_bcd_d4_kept", 32'(bcd_out[3:0]), 32'd0);
    check("t4_err_count_2", 32'(err_count), 32'd2);
    for (int i = 0; i < 150; i++) begin
      show(12'h000, 7);
      show(12'hFC3, 7);
    end
    repeat (8) @(negedge clk);
    check("t4_err_saturated", 32'(err_count), 32'd255);
    @(negedge clk);
    hex_in = 12'h000;
    repeat (6) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    check("t4_coincident_err", 32'(enable_err), 32'd1);
    check("t4_coincident_clr", 32'(err_count), 32'd0);
    err_clr = 1'b0;
    show(12'hFC3, 10);
    check("t4_err_count_after", 32'(err_count), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", 32'(err_count), 32'd0);

    // 5: D2 '2' then blank bus until timeout
    show(12'hCF3, 10);
    a = last_pulse_edge;
    check("t5_bcd_d2", 32'(bcd_out[11:8]), 32'd2);
    check("t5_valid_d2_set", 32'(digit_valid[2]), 32'd1);
    hex_in = 12'h9A0;
    for (int w = 0; w < 200 && ecount < a + T - 1; w++) @(negedge clk);
    check("t5_wait_edge", 32'(ecount), 32'(a + T - 1));
    check("t5_valid_before_timeout", 32'(digit_valid[2]), 32'd1);
    @(negedge clk);
    check("t5_valid_timed_out", 32'(digit_valid[2]), 32'd0);
    check("t5_bcd_d2_kept", 32'(bcd_out[11:8]), 32'd2);

    // 6: reset mid-scan, release with stable bus
    show(12'h000, 8);
    check("t6_err_before_reset", 32'(err_count), 32'd1);
    show(12'h7FA, 8);
    show(12'hCFA, 3);
    #3 reset_n = 1'b0;
    #1;
    check("t6_reset_bcd", 32'(bcd_out), 32'h0);
    check("t6_reset_valid", 32'(digit_valid), 32'h0);
    check("t6_reset_pulse", 32'(update_pulse), 32'h0);
    check("t6_reset_digit", 32'(update_digit), 32'h0);
    check("t6_reset_errs", 32'(err_count), 32'h0);
    @(negedge clk);
    hex_in = 12'hFCB;
    @(negedge clk);
    reset_n = 1'b1; r1 = ecount + 1; p0 = pulse_cnt;
    repeat (10) @(negedge clk);
    check("t6_pulses_after_release", 32'(pulse_cnt - p0), 32'd1);
    check("t6_pulse_edge", 32'(last_pulse_edge), 32'(r1 + 6));
    repeat (2) @(negedge clk);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
